uart_fifo_gen2: RTL

UART_FIFO_GEN2 -- requirements
Module: uart_fifo_gen2

---
 rtl/uart_fifo_gen2_if.sv | 41 ++++
 rtl/uart_fifo_gen2.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_fifo_gen2_if.sv
// ---------------------------------------------------------------------------
// uart_fifo_gen2_if : handshake/status bundle for the uart_fifo_gen2 FIFO. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_fifo_gen2_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_BITS = 4
);
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DEPTH_BITS:0]   af_level;
  logic [DEPTH_BITS:0]   ae_level;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [DEPTH_BITS:0]   count;
  logic [DEPTH_BITS:0]   high_water;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, pop, flush, clr_err, data_in, af_level, ae_level,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, high_water, overflow, underflow
  );

  modport slave (
    input  push, pop, flush, clr_err, data_in, af_level, ae_level,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           count, high_water, overflow, underflow
  );
endinterface

`default_nettype wire

// File: rtl/uart_fifo_gen2.sv
// ---------------------------------------------------------------------------
// uart_fifo_gen2 : synchronous FIFO with level flags, sticky errors, peak level
// tracking and selectable show-ahead / registered read. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_fifo_gen2 #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_BITS = 4,
  parameter int FWFT       = 1
) (
  input  wire logic         clk,
  input  wire logic         rstn,
  uart_fifo_gen2_if.slave   bus
);

  localparam int unsigned       DEPTH      = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] c_full_cnt = (DEPTH_BITS+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q,  count_d;
  logic [DEPTH_BITS:0]   hw_q,     hw_d;
  logic                  ovf_q,    ovf_d;
  logic                  udf_q,    udf_d;

  logic full_w;
  logic empty_w;
  logic push_acc;
  logic pop_acc;
  logic ovf_set;
  logic udf_set;

  // Flags come from the registered count so they never depend on this cycle's requests.
  always_comb begin
    full_w   = (count_q == c_full_cnt);
    empty_w  = (count_q == '0);
    push_acc = bus.push & ~full_w  & ~bus.flush;
    pop_acc  = bus.pop  & ~empty_w & ~bus.flush;
    ovf_set  = bus.push &  full_w  & ~bus.flush;
    udf_set  = bus.pop  &  empty_w & ~bus.flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
      if (pop_acc)  rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + (DEPTH_BITS+1)'(1);
        2'b01:   count_d = count_q - (DEPTH_BITS+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // A new error event in the same cycle as clr_err leaves the flag set.
  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~bus.clr_err);
    udf_d = udf_set | (udf_q & ~bus.clr_err);
    hw_d  = hw_q;
    if (bus.clr_err) begin
      hw_d = count_d;
    end else if (count_d > hw_q) begin
      hw_d = count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hw_q     <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hw_q     <= hw_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rstn && push_acc) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= bus.af_level);
  assign bus.almost_empty = (count_q <= bus.ae_level);
  assign bus.count        = count_q;
  assign bus.high_water   = hw_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = empty_w ? '0 : mem_q[rd_ptr_q];
      assign bus.rd_valid = ~empty_w;
    end else begin : g_regrd
      logic [DATA_WIDTH-1:0] dout_q, dout_d;
      logic                  rdv_q,  rdv_d;

      // rd_valid is a one-cycle strobe; a flush never accepts a pop so it drops it.
      always_comb begin
        dout_d = pop_acc ? mem_q[rd_ptr_q] : dout_q;
        rdv_d  = pop_acc;
      end

      always_ff @(posedge clk) begin
        if (!rstn) begin
          dout_q <= '0;
          rdv_q  <= 1'b0;
        end else begin
          dout_q <= dout_d;
          rdv_q  <= rdv_d;
        end
      end

      assign bus.data_out = dout_q;
      assign bus.rd_valid = rdv_q;
    end
  endgenerate

endmodule

`default_nettype wire
